// File: rtl/tpu_tile_scheduler.sv
// Walks 4x4 output tiles of an m x k by k x n matmul, issuing LOAD/EXE/STORE per tile.
// Optional TPU_SCHED_PERF_EN adds saturating busy-cycle and stall-cycle counters.
module tpu_tile_scheduler #(
  parameter int IDX_W = 8,
  parameter int TILE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       m,
  input  logic [3:0]       n,
  input  logic [3:0]       k,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  input  logic             cmd_ready,
  input  logic             cmd_done,
  output logic [IDX_W-1:0] base_a,
  output logic [IDX_W-1:0] base_b,
  output logic [IDX_W-1:0] base_o,
  output logic [2:0]       tile_rows,
  output logic [2:0]       tile_cols,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef TPU_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_cycles,
  output logic [15:0]      perf_stall
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ISS_LD, S_WAIT_LD, S_ISS_EX, S_WAIT_EX,
    S_ISS_ST, S_WAIT_ST, S_NEXT, S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_EXE   = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t           state_q;
  logic [3:0]       m_q, n_q, k_q;
  logic [1:0]       r_q, c_q;
  logic             cmd_valid_q;
  logic [1:0]       cmd_op_q;
  logic [IDX_W-1:0] base_a_q, base_b_q, base_o_q;
  logic [2:0]       tile_rows_q, tile_cols_q;
  logic             busy_q, done_q, err_q;

  logic [3:0]       m_m1, n_m1;
  logic [1:0]       r_last, c_last;
  logic             last_tile;
  logic [1:0]       r_d, c_d;
  logic [IDX_W-1:0] r_w, c_w, m_w, k_w;
  logic [IDX_W-1:0] base_a_d, base_b_d, base_o_d;
  logic [3:0]       rem_r, rem_c;
  logic [2:0]       tile_rows_d, tile_cols_d;

  // Index of the last row/column tile is (dim-1)/4; dims are nonzero once past CHECK.
  assign m_m1      = m_q - 4'd1;
  assign n_m1      = n_q - 4'd1;
  assign r_last    = m_m1[3:2];
  assign c_last    = n_m1[3:2];
  assign last_tile = (r_q == r_last) && (c_q == c_last);

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (state_q == S_CHECK) begin
      r_d = 2'd0;
      c_d = 2'd0;
    end else if (r_q != r_last) begin
      r_d = r_q + 2'd1;
    end else begin
      r_d = 2'd0;
      c_d = c_q + 2'd1;
    end
    r_w         = IDX_W'(r_d);
    c_w         = IDX_W'(c_d);
    m_w         = IDX_W'(m_q);
    k_w         = IDX_W'(k_q);
    base_a_d    = r_w * k_w;
    base_b_d    = c_w * k_w;
    base_o_d    = c_w * m_w + r_w * IDX_W'(TILE);
    rem_r       = m_q - {r_d, 2'b00};
    rem_c       = n_q - {c_d, 2'b00};
    tile_rows_d = (rem_r >= 4'd4) ? 3'd4 : rem_r[2:0];
    tile_cols_d = (rem_c >= 4'd4) ? 3'd4 : rem_c[2:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_LOAD;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_o_q    <= '0;
      tile_rows_q <= '0;
      tile_cols_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q     <= m;
            n_q     <= n;
            k_q     <= k;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q <= 1'b0;
          if (m_q == 4'd0 || n_q == 4'd0 || k_q == 4'd0) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            busy_q      <= 1'b1;
            r_q         <= r_d;
            c_q         <= c_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_o_q    <= base_o_d;
            tile_rows_q <= tile_rows_d;
            tile_cols_q <= tile_cols_d;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_LOAD;
            state_q     <= S_ISS_LD;
          end
        end
        S_ISS_LD: if (cmd_ready) begin cmd_valid_q <= 1'b0; state_q <= S_WAIT_LD; end
        S_ISS_EX: if (cmd_ready) begin cmd_valid_q <= 1'b0; state_q <= S_WAIT_EX; end
        S_ISS_ST: if (cmd_ready) begin cmd_valid_q <= 1'b0; state_q <= S_WAIT_ST; end
        S_WAIT_LD: begin
          if (cmd_done) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_EXE;
            state_q     <= S_ISS_EX;
          end
        end
        S_WAIT_EX: begin
          if (cmd_done) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_STORE;
            state_q     <= S_ISS_ST;
          end
        end
        S_WAIT_ST: if (cmd_done) state_q <= S_NEXT;
        S_NEXT: begin
          if (last_tile) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_o_q    <= base_o_d;
            tile_rows_q <= tile_rows_d;
            tile_cols_q <= tile_cols_d;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_LOAD;
            state_q     <= S_ISS_LD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TPU_SCHED_PERF_EN
  logic [15:0] perf_cycles_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_q && perf_cycles_q != 16'hFFFF)
        perf_cycles_q <= perf_cycles_q + 16'd1;
      if (cmd_valid_q && !cmd_ready && perf_stall_q != 16'hFFFF)
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign base_a    = base_a_q;
  assign base_b    = base_b_q;
  assign base_o    = base_o_q;
  assign tile_rows = tile_rows_q;
  assign tile_cols = tile_cols_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler: single tile, 6x5x3 tiling, stalls, errors, reset abort.
module tb_tpu_tile_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] m_in = '0, n_in = '0, k_in = '0;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready = 1'b0;
  logic       cmd_done = 1'b0;
  logic [7:0] base_a, base_b, base_o;
  logic [2:0] tile_rows, tile_cols;
  logic       busy, done, err;
`ifdef TPU_SCHED_PERF_EN
  logic [15:0] perf_cycles, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a [4] = '{8'd0, 8'd3, 8'd0, 8'd3};
  logic [7:0] exp_b [4] = '{8'd0, 8'd0, 8'd3, 8'd3};
  logic [7:0] exp_o [4] = '{8'd0, 8'd4, 8'd6, 8'd10};
  logic [2:0] exp_r [4] = '{3'd4, 3'd2, 3'd4, 3'd2};
  logic [2:0] exp_c [4] = '{3'd4, 3'd4, 3'd1, 3'd1};

  always #5 clk = ~clk;

  tpu_tile_scheduler #(.IDX_W(8), .TILE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m_in), .n(n_in), .k(k_in),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .base_a(base_a), .base_b(base_b), .base_o(base_o),
    .tile_rows(tile_rows), .tile_cols(tile_cols),
    .busy(busy), .done(done), .err(err)
`ifdef TPU_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launches a job; scrambles the dimension inputs afterwards to prove they were latched.
  task automatic start_job(input logic [3:0] mm, input logic [3:0] nn, input logic [3:0] kk);
    m_in = mm; n_in = nn; k_in = kk;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_in = 4'd0; n_in = 4'd0; k_in = 4'd0;
    chk("check_no_valid", {15'd0, cmd_valid}, 16'd0);
    tick;
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] ea,
                        input logic [7:0] eb, input logic [7:0] eo, input logic [2:0] er,
                        input logic [2:0] ec, input int nrdy, input bit stray);
    int t;
    cmd_ready = (nrdy == 0);
    t = 0;
    while (!cmd_valid && t < 20) begin tick; t++; end
    start = 1'b0;
    chk({tag, "_valid"}, {15'd0, cmd_valid}, 16'd1);
    chk({tag, "_op"}, {14'd0, cmd_op}, {14'd0, op});
    chk({tag, "_base_a"}, {8'd0, base_a}, {8'd0, ea});
    chk({tag, "_base_b"}, {8'd0, base_b}, {8'd0, eb});
    chk({tag, "_base_o"}, {8'd0, base_o}, {8'd0, eo});
    chk({tag, "_rows"}, {13'd0, tile_rows}, {13'd0, er});
    chk({tag, "_cols"}, {13'd0, tile_cols}, {13'd0, ec});
    for (int i = 0; i < nrdy; i++) begin
      cmd_done = stray;
      tick;
      cmd_done = 1'b0;
      chk({tag, "_stall_valid"}, {15'd0, cmd_valid}, 16'd1);
      chk({tag, "_stall_op"}, {14'd0, cmd_op}, {14'd0, op});
      chk({tag, "_stall_base_o"}, {8'd0, base_o}, {8'd0, eo});
    end
    cmd_ready = 1'b1;
    cmd_done  = stray;
    tick;
    cmd_done = 1'b0;
    chk({tag, "_accepted"}, {15'd0, cmd_valid}, 16'd0);
    tick;
    chk({tag, "_waiting"}, {15'd0, cmd_valid}, 16'd0);
    cmd_done = 1'b1;
    tick;
    cmd_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 20) begin tick; t++; end
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_busy_at_done"}, {15'd0, busy}, 16'd1);
    chk({tag, "_no_cmd"}, {15'd0, cmd_valid}, 16'd0);
    tick;
    chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    chk({tag, "_busy_off"}, {15'd0, busy}, 16'd0);
    chk({tag, "_err"}, {15'd0, err}, 16'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick;
    tick;
    chk("rst_valid", {15'd0, cmd_valid}, 16'd0);
    chk("rst_op", {14'd0, cmd_op}, 16'd0);
    chk("rst_base_a", {8'd0, base_a}, 16'd0);
    chk("rst_base_o", {8'd0, base_o}, 16'd0);
    chk("rst_rows", {13'd0, tile_rows}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    rst = 1'b1;
    tick;

    // Single 4x4x4 tile; first command two cycles after start
    start_job(4'd4, 4'd4, 4'd4);
    chk("lat_valid", {15'd0, cmd_valid}, 16'd1);
    chk("lat_busy", {15'd0, busy}, 16'd1);
    do_cmd("t44_ld", 2'd0, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    do_cmd("t44_ex", 2'd1, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    do_cmd("t44_st", 2'd2, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    wait_done("t44");

    // Zero dimension: error with a done pulse and no commands
    start_job(4'd4, 4'd4, 4'd0);
    chk("err_done", {15'd0, done}, 16'd1);
    chk("err_flag", {15'd0, err}, 16'd1);
    chk("err_busy", {15'd0, busy}, 16'd0);
    chk("err_no_cmd", {15'd0, cmd_valid}, 16'd0);
    tick;
    chk("err_done_pulse", {15'd0, done}, 16'd0);
    chk("err_sticky", {15'd0, err}, 16'd1);
    tick;
    chk("err_idle_no_cmd", {15'd0, cmd_valid}, 16'd0);

    // 6x5x3: four tiles, err cleared by the new start
    start_job(4'd6, 4'd5, 4'd3);
    chk("err_cleared", {15'd0, err}, 16'd0);
    for (int t = 0; t < 4; t++) begin
      do_cmd("j65_ld", 2'd0, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t], 0, 1'b0);
      do_cmd("j65_ex", 2'd1, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t], 0, 1'b0);
      do_cmd("j65_st", 2'd2, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t], 0, 1'b0);
    end
    wait_done("j65");

    // Reset while waiting on the EXE of the second tile
    start_job(4'd6, 4'd5, 4'd3);
    do_cmd("ab_ld0", 2'd0, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    do_cmd("ab_ex0", 2'd1, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    do_cmd("ab_st0", 2'd2, 8'd0, 8'd0, 8'd0, 3'd4, 3'd4, 0, 1'b0);
    do_cmd("ab_ld1", 2'd0, 8'd3, 8'd0, 8'd4, 3'd2, 3'd4, 0, 1'b0);
    chk("ab_ex1_valid", {15'd0, cmd_valid}, 16'd1);
    chk("ab_ex1_op", {14'd0, cmd_op}, 16'd1);
    tick;
    chk("ab_in_wait", {15'd0, cmd_valid}, 16'd0);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("ab_valid", {15'd0, cmd_valid}, 16'd0);
    chk("ab_op", {14'd0, cmd_op}, 16'd0);
    chk("ab_base_a", {8'd0, base_a}, 16'd0);
    chk("ab_base_o", {8'd0, base_o}, 16'd0);
    chk("ab_cols", {13'd0, tile_cols}, 16'd0);
    chk("ab_busy", {15'd0, busy}, 16'd0);
    chk("ab_done", {15'd0, done}, 16'd0);
    tick;
    chk("ab_still_idle", {15'd0, busy}, 16'd0);

    // Fresh job after abort: EXE stall with stray dones, ignored mid-job start
    start_job(4'd6, 4'd5, 4'd3);
    for (int t = 0; t < 4; t++) begin
      if (t == 1) begin
        m_in = 4'd15;
        start = 1'b1;
      end
      do_cmd("rs_ld", 2'd0, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t], 0, 1'b0);
      do_cmd("rs_ex", 2'd1, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t],
             (t == 0) ? 5 : 0, (t == 0));
      do_cmd("rs_st", 2'd2, exp_a[t], exp_b[t], exp_o[t], exp_r[t], exp_c[t], 0, 1'b0);
    end
    wait_done("rs");
`ifdef TPU_SCHED_PERF_EN
    // 4 tiles x 10 busy cycles + 5 stall cycles + DONE cycle
    chk("perf_cycles", perf_cycles, 16'd46);
    chk("perf_stall", perf_stall, 16'd5);
    tick;
    chk("perf_cycles_hold", perf_cycles, 16'd46);
`endif
    tick;
    chk("end_idle_no_cmd", {15'd0, cmd_valid}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
